// File: rtl/fpu_op_arbiter.sv
// rtl/fpu_op_arbiter.sv - round-robin arbiter sharing one non-pipelined FPU core between two requesters
//
// Purpose:
//   Accepts fpu_instruction_t packets from two requesters over valid/ready,
//   grants one at a time (round-robin), starts the core with a one-cycle
//   pulse, waits for core_done and returns the result tagged with the
//   requester id. Exactly one operation is outstanding at any time.
//
// Instruction packing (69 bits): {fpu_op[68:66], rmode[65:64], opa[63:32], opb[31:0]}
//   fpu_op 0..3 are legal; 4..7 are answered directly with resp_err=1 and a quiet NaN.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   req_valid[1:0]          per-requester instruction valid
//   req_ready[1:0]          per-requester accept, at most one bit high, only in IDLE
//   req_instr0/1[68:0]      instruction from requester 0 / 1
//   core_start              one-cycle pulse that starts the core
//   core_instr[68:0]        latched instruction, stable from start until done
//   core_done, core_result  core result strobe and 32-bit result
//   resp_valid/resp_ready   response handshake
//   resp_id, resp_result    owning requester and result
//   resp_err                illegal opcode (or watchdog timeout)
//   busy                    high whenever the state is not IDLE
//
// Optional feature: define FPU_TIMEOUT_EN to enable the core_start->core_done
//   watchdog (TIMEOUT_CYCLES, CNT_W). Without it WAIT lasts until core_done.

module fpu_op_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [68:0] req_instr0,
  input  logic [68:0] req_instr1,
  output logic        core_start,
  output logic [68:0] core_instr,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // The watchdog needs room to count and a WAIT phase of at least one cycle.
  if ((1 << CNT_W) <= TIMEOUT_CYCLES || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("fpu_op_arbiter: need 2**CNT_W > TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        id_q, id_d;
  logic [68:0] instr_q, instr_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  logic        grant_vld;
  logic        grant_id;
  logic [68:0] grant_instr;
  logic        grant_illegal;
  logic        req_hs;
  logic        timeout;

  // Preferred requester wins if it is asking; otherwise the other one.
  always_comb begin
    grant_vld     = req_valid[rr_ptr_q] | req_valid[~rr_ptr_q];
    grant_id      = req_valid[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    grant_instr   = grant_id ? req_instr1 : req_instr0;
    grant_illegal = grant_instr[68];
    req_hs        = (state_q == IDLE) && grant_vld;
  end

`ifdef FPU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // cnt_q counts WAIT cycles already spent; the WAIT cycle with
  // cnt_q == TIMEOUT_CYCLES-2 is the last one, so the error response appears
  // exactly TIMEOUT_CYCLES cycles after the core_start cycle. A done arriving
  // in that last cycle still wins; anything later lands in RESP and is ignored.
  assign timeout = (state_q == WAIT) && !core_done &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      instr_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = grant_illegal ? RESP : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (core_done || timeout) state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    instr_d  = instr_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          id_d    = grant_id;
          instr_d = grant_instr;
          err_d   = grant_illegal;
          if (grant_illegal) result_d = QNAN;
        end
      end
      WAIT: begin
        if (core_done) begin
          result_d = core_result;
          err_d    = 1'b0;
        end else if (timeout) begin
          result_d = QNAN;
          err_d    = 1'b1;
        end
      end
      RESP: begin
        // Pointer moves only on a completed response, illegal ones included.
        if (resp_ready) rr_ptr_d = ~id_q;
      end
      default: ;
    endcase
  end

  // Outputs. req_ready is gated by rst_n so every output is low during reset.
  always_comb begin
    req_ready  = 2'b00;
    core_start = 1'b0;
    resp_valid = 1'b0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE:    if (rst_n && grant_vld) req_ready = grant_id ? 2'b10 : 2'b01;
      ISSUE:   core_start = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign core_instr  = instr_q;
  assign resp_id     = id_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// tb/tb_fpu_op_arbiter.sv - directed self-checking bench for fpu_op_arbiter

`define CHK(tag, obs, exp) chk(tag, 69'(obs), 69'(exp))

module tb_fpu_op_arbiter;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [68:0] req_instr0, req_instr1;
  logic        core_start;
  logic [68:0] core_instr;
  logic        core_done;
  logic [31:0] core_result;
  logic        resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [31:0] resp_result;

  int n_assert = 0;
  int n_fail   = 0;
  int starts   = 0;

  logic [68:0] i_add0, i_mul0, i_sub1, i_div1, i_bad1;

  always #5 clk = ~clk;

  always @(posedge clk) if (core_start === 1'b1) starts <= starts + 1;

  fpu_op_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_instr0(req_instr0), .req_instr1(req_instr1),
    .core_start(core_start), .core_instr(core_instr),
    .core_done(core_done), .core_result(core_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_result(resp_result),
    .resp_err(resp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] vmask, input logic exp_g,
                        input logic [68:0] i0, input logic [68:0] i1, input logic [31:0] res);
    logic [68:0] exp_i;
    exp_i = exp_g ? i1 : i0;
    req_valid = vmask; req_instr0 = i0; req_instr1 = i1;
    #1;
    `CHK({tag, ".grant"}, req_ready, (2'b01 << exp_g));
    tick();
    `CHK({tag, ".start"}, core_start, 1'b1);
    `CHK({tag, ".instr"}, core_instr, exp_i);
    `CHK({tag, ".ready_busy"}, req_ready, 2'b00);
    tick();
    `CHK({tag, ".start_off"}, core_start, 1'b0);
    core_done = 1'b1; core_result = res;
    tick();
    core_done = 1'b0; core_result = '0;
    `CHK({tag, ".resp_valid"}, resp_valid, 1'b1);
    `CHK({tag, ".resp_id"}, resp_id, exp_g);
    `CHK({tag, ".resp_result"}, resp_result, res);
    `CHK({tag, ".resp_err"}, resp_err, 1'b0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    `CHK({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    i_add0 = {3'd0, 2'd0, 32'h3F800000, 32'h40000000};
    i_mul0 = {3'd2, 2'd1, 32'h40400000, 32'h40800000};
    i_sub1 = {3'd1, 2'd2, 32'h41000000, 32'h3F800000};
    i_div1 = {3'd3, 2'd3, 32'h41200000, 32'h40000000};
    i_bad1 = {3'b101, 2'd0, 32'h00000001, 32'h00000002};

    rst_n = 1'b0; req_valid = 2'b00; req_instr0 = '0; req_instr1 = '0;
    core_done = 1'b0; core_result = '0; resp_ready = 1'b0;
    #1;
    `CHK("rst.req_ready", req_ready, 2'b00);
    `CHK("rst.core_start", core_start, 1'b0);
    `CHK("rst.core_instr", core_instr, 69'd0);
    `CHK("rst.resp_valid", resp_valid, 1'b0);
    `CHK("rst.resp_result", resp_result, 32'd0);
    `CHK("rst.busy", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    req_valid = 2'b01; req_instr0 = i_add0;
    #1;
    `CHK("single.ready", req_ready, 2'b01);
    `CHK("single.busy0", busy, 1'b0);
    tick();
    req_valid = 2'b00;
    `CHK("single.start", core_start, 1'b1);
    `CHK("single.instr", core_instr, i_add0);
    `CHK("single.busy1", busy, 1'b1);
    tick();
    `CHK("single.start_off", core_start, 1'b0);
    `CHK("single.no_resp_t2", resp_valid, 1'b0);
    tick();
    core_done = 1'b1; core_result = 32'h40400000;
    #1;
    `CHK("single.no_resp_t3", resp_valid, 1'b0);
    tick();
    core_done = 1'b0; core_result = '0;
    `CHK("single.resp_valid", resp_valid, 1'b1);
    `CHK("single.resp_id", resp_id, 1'b0);
    `CHK("single.resp_result", resp_result, 32'h40400000);
    `CHK("single.resp_err", resp_err, 1'b0);
    `CHK("single.one_start", starts, 1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    `CHK("single.idle", busy, 1'b0);
    `CHK("single.resp_drop", resp_valid, 1'b0);

    req_valid = 2'b10; req_instr1 = i_bad1;
    #1;
    `CHK("illegal.ready", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    `CHK("illegal.resp_valid", resp_valid, 1'b1);
    `CHK("illegal.no_start", core_start, 1'b0);
    `CHK("illegal.resp_id", resp_id, 1'b1);
    `CHK("illegal.resp_err", resp_err, 1'b1);
    `CHK("illegal.resp_result", resp_result, QNAN);
    `CHK("illegal.core_instr", core_instr, i_bad1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    `CHK("illegal.idle", busy, 1'b0);
    `CHK("illegal.start_count", starts, 1);

    run_op("cont0", 2'b11, 1'b0, i_mul0, i_sub1, 32'h41400000);
    run_op("cont1", 2'b11, 1'b1, i_mul0, i_sub1, 32'h40E00000);
    run_op("cont2", 2'b11, 1'b0, i_add0, i_div1, 32'h40400000);
    run_op("cont3", 2'b11, 1'b1, i_add0, i_div1, 32'h40A00000);
    req_valid = 2'b00;
    `CHK("cont.start_count", starts, 5);

    req_valid = 2'b01; req_instr0 = i_mul0;
    #1;
    `CHK("bp.ready0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10; req_instr1 = i_sub1;
    #1;
    `CHK("bp.start", core_start, 1'b1);
    `CHK("bp.ready_issue", req_ready, 2'b00);
    tick();
    core_done = 1'b1; core_result = 32'h12345678;
    tick();
    core_done = 1'b0; core_result = '0;
    for (int i = 0; i < 10; i++) begin
      `CHK("bp.resp_valid", resp_valid, 1'b1);
      `CHK("bp.resp_result", resp_result, 32'h12345678);
      `CHK("bp.resp_id", resp_id, 1'b0);
      `CHK("bp.resp_err", resp_err, 1'b0);
      `CHK("bp.req_ready", req_ready, 2'b00);
      `CHK("bp.busy", busy, 1'b1);
      n_assert++;
      if (resp_valid !== 1'b1 || resp_result !== 32'h12345678) begin
        n_fail++;
        $error("FAIL bp.hold_resp: valid %b result %h", resp_valid, resp_result);
      end
      n_assert++;
      if (req_ready !== 2'b00 || busy !== 1'b1) begin
        n_fail++;
        $error("FAIL bp.hold_busy: req_ready %b busy %b", req_ready, busy);
      end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    `CHK("bp.no_accept_on_hs", req_ready, 2'b00);
    tick();
    resp_ready = 1'b0;
    `CHK("bp.ready1", req_ready, 2'b10);
    `CHK("bp.idle", busy, 1'b0);
    tick();
    req_valid = 2'b00;
    `CHK("bp.start1", core_start, 1'b1);
    `CHK("bp.instr1", core_instr, i_sub1);

    tick();
    `CHK("rmid.in_wait", busy, 1'b1);
    req_valid = 2'b11;
    #1;
    rst_n = 1'b0;
    #1;
    `CHK("rmid.req_ready", req_ready, 2'b00);
    `CHK("rmid.core_start", core_start, 1'b0);
    `CHK("rmid.core_instr", core_instr, 69'd0);
    `CHK("rmid.resp_valid", resp_valid, 1'b0);
    `CHK("rmid.resp_id", resp_id, 1'b0);
    `CHK("rmid.resp_result", resp_result, 32'd0);
    `CHK("rmid.resp_err", resp_err, 1'b0);
    `CHK("rmid.busy", busy, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    `CHK("rmid.prefer0", req_ready, 2'b01);
    req_valid = 2'b00;

    core_done = 1'b1; core_result = 32'hDEADBEEF;
    tick();
    core_done = 1'b0; core_result = '0;
    `CHK("stray.resp_valid", resp_valid, 1'b0);
    `CHK("stray.busy", busy, 1'b0);

`ifdef FPU_TIMEOUT_EN
    req_valid = 2'b01; req_instr0 = i_add0;
    tick();
    req_valid = 2'b00;
    `CHK("to.start", core_start, 1'b1);
    for (int k = 1; k < 8; k++) begin
      tick();
      `CHK("to.waiting", resp_valid, 1'b0);
    end
    tick();
    `CHK("to.resp_valid", resp_valid, 1'b1);
    `CHK("to.resp_err", resp_err, 1'b1);
    `CHK("to.resp_result", resp_result, QNAN);
    core_done = 1'b1; core_result = 32'h40400000;
    tick();
    core_done = 1'b0; core_result = '0;
    `CHK("to.late_err", resp_err, 1'b1);
    `CHK("to.late_result", resp_result, QNAN);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    `CHK("to.idle", busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_op_arbiter.md
Name: fpu_op_arbiter

Overview:
Shares one non-pipelined FPU core between two instruction requesters.
- Accepts fpu_instruction_t packets (fpu_op, rmode, opa, opb) over valid/ready.
- Arbitrates round-robin, issues one start pulse to the core and waits for its done strobe.
- Returns the 32-bit result tagged with the requester id.
- Sits between the instruction-issue front end and the FPU datapath. Exactly one operation is outstanding at any time.

Parameters:
TIMEOUT_CYCLES, 64, watchdog limit in cycles from core_start to core_done. Used only when FPU_TIMEOUT_EN is defined.
CNT_W, 7, watchdog counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester instruction valid (bit i = requester i)
req_ready  out  2  per-requester accept; at most one bit high in any cycle
req_instr0  in  69  fpu_instruction_t from requester 0
req_instr1  in  69  fpu_instruction_t from requester 1
core_start  out  1  one-cycle pulse that starts the core
core_instr  out  69  latched instruction; stable from start until done
core_done  in  1  core result-valid strobe (one cycle)
core_result  in  32  core result (float_t), valid with core_done
resp_valid  out  1  response valid
resp_ready  in  1  response consumer accept
resp_id  out  1  requester that owns the response
resp_result  out  32  result
resp_err  out  1  1 = illegal opcode (or timeout, if enabled)
busy  out  1  high whenever the state is not IDLE

Behaviour:
Reset (rst_n low, asynchronous):
- State = IDLE; all outputs = 0; rr_ptr = 0 (requester 0 preferred).
- Reset mid-operation abandons the operation with no response. The core shares rst_n.

States: IDLE, ISSUE, WAIT, RESP.

IDLE:
- Grant g = rr_ptr if req_valid[rr_ptr]; otherwise the other requester if its valid is high.
- req_ready[g] = 1 combinationally, only in IDLE.
- On handshake: latch instr and id=g.
- Legal op (fpu_op 0..3) -> ISSUE.
- Illegal op (4..7) -> RESP with resp_err=1, resp_result=32'h7FC00000, and no core_start.

ISSUE:
- core_start=1 for exactly one cycle -> WAIT.

WAIT:
- core_done is sampled only in WAIT; a core_done seen in any other state is ignored.
- On core_done: capture core_result, resp_err=0 -> RESP.

RESP:
- resp_valid=1; resp_id, resp_result and resp_err are held stable until resp_ready.
- On handshake: rr_ptr <= ~resp_id, state -> IDLE.
- No new request is accepted in the same cycle as the handshake.

Timing:
- Minimum latency is request handshake at cycle T, core_start at T+1, core_done at T+2 at the earliest, resp_valid at T+3.
- Throughput is at most one operation per 4 cycles.

Arbitration:
- Both req_valid high: rr_ptr decides.
- rr_ptr flips only on a completed response, which includes illegal-op responses.
- With alternating contention the grants strictly alternate.

Other rules:
- core_instr is a registered copy of the latched instruction; it changes only on a request handshake.
- Requester valid may drop without acceptance; there is no obligation to hold.

Optional Feature:
Macro FPU_TIMEOUT_EN.
- Defined: CNT_W counter clears on core_start and increments in WAIT. If it reaches TIMEOUT_CYCLES without core_done -> RESP with resp_err=1 and resp_result=32'h7FC00000. A core_done arriving at or after the timeout is ignored.
- Undefined: no counter; WAIT lasts until core_done indefinitely. resp_err is set only for illegal opcodes.

Test Plan:
1. Single op
   - Stimulus: req0 ADD, opa=32'h3F800000, opb=32'h40000000, core model done after 2 cycles returning 32'h40400000.
   - Required: resp_valid at T+4, resp_id=0, resp_result=32'h40400000, resp_err=0, exactly one core_start pulse.
2. Contention
   - Stimulus: req0 and req1 both held valid for 4 ops.
   - Required: grants go 0,1,0,1; rr_ptr flips after each response.
3. Illegal op
   - Stimulus: req1 fpu_op=3'b101.
   - Required: no core_start; RESP with resp_id=1, resp_err=1, resp_result=32'h7FC00000.
4. Backpressure
   - Stimulus: resp_ready held low 10 cycles.
   - Required: resp fields stable; req_ready stays 0; busy=1; a pending req1 is accepted one cycle after the resp handshake.
5. Reset mid-operation
   - Stimulus: rst_n low while in WAIT.
   - Required: all outputs 0 immediately (asynchronous); after release, state IDLE and requester 0 preferred.
6. Timeout (FPU_TIMEOUT_EN, TIMEOUT_CYCLES=8)
   - Stimulus: core never asserts done.
   - Required: resp_err=1 and resp_result=32'h7FC00000 at 8 cycles after core_start; a late core_done is ignored.
